// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the byte-serial ALU command sequencer.
package alu_seq_pkg;
  localparam int OPC_W         = 3;
  localparam int DATA_W        = 8;
  localparam int BYTES_PER_CMD = 3;

  typedef enum logic [2:0] {
    GET_OP = 3'd0,
    GET_A  = 3'd1,
    GET_B  = 3'd2,
    EXEC   = 3'd3,
    HOLD   = 3'd4,
    DRAIN  = 3'd5
  } state_t;
endpackage

// File: rtl/alu_seq_result_reg.sv
// Valid/ready holding register for one ALU result; done pulses on handshake.
module alu_seq_result_reg
  import alu_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] y,
  input  logic [OPC_W-1:0]  op,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [OPC_W-1:0]  res_opcode,
  output logic              done
);
  assign done = res_valid && res_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_opcode <= '0;
    end else if (load) begin
      res_valid  <= 1'b1;
      res_data   <= y;
      res_opcode <= op;
    end else if (done) begin
      res_valid  <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_cmd_sequencer.sv
// Byte-serial command front end for the 8-bit ALU: opcode, A, B in; Y out on valid/ready.
// Optional opcode range check (bits [7:3] must be 0) enabled by ALU_SEQ_OPCHK_EN.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [OPC_W-1:0]  res_opcode,
  output logic [CNT_W-1:0]  cmd_count,
  output logic              busy
`ifdef ALU_SEQ_OPCHK_EN
  ,
  output logic              err_opcode
`endif
);
  localparam int EW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  state_t          state, state_nx;
  logic [EW-1:0]   exec_cnt;
  logic [OPC_W-1:0] opc_q;
  logic            xfer, load, done;
`ifdef ALU_SEQ_OPCHK_EN
  logic            bad_op;
  logic [1:0]      drain_cnt;
  assign bad_op = |in_data[DATA_W-1:OPC_W];
`else
  logic            unused_hi;
  assign unused_hi = ^in_data[DATA_W-1:OPC_W];
`endif

  assign xfer       = in_valid && in_ready;
  assign busy       = (state != GET_OP);
  assign alu_opcode = opc_q;
  // Y is sampled one cycle after entering HOLD so the operands have settled a full cycle past the counter.
  assign load       = (state == HOLD) && !res_valid;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      GET_OP: begin
        in_ready = 1'b1;
        if (xfer) begin
`ifdef ALU_SEQ_OPCHK_EN
          state_nx = bad_op ? DRAIN : GET_A;
`else
          state_nx = GET_A;
`endif
        end
      end
      GET_A: begin
        in_ready = 1'b1;
        if (xfer) state_nx = GET_B;
      end
      GET_B: begin
        in_ready = 1'b1;
        if (xfer) state_nx = EXEC;
      end
      EXEC:  if (exec_cnt == '0) state_nx = HOLD;
      HOLD:  if (done) state_nx = GET_OP;
`ifdef ALU_SEQ_OPCHK_EN
      DRAIN: begin
        in_ready = 1'b1;
        if (xfer && drain_cnt == 2'(BYTES_PER_CMD - 2)) state_nx = GET_OP;
      end
`endif
      default: state_nx = GET_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= GET_OP;
      opc_q     <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      exec_cnt  <= '0;
      cmd_count <= '0;
`ifdef ALU_SEQ_OPCHK_EN
      drain_cnt  <= '0;
      err_opcode <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (done) cmd_count <= cmd_count + CNT_W'(1);
      if (state == EXEC && exec_cnt != '0) exec_cnt <= exec_cnt - EW'(1);
      if (xfer) begin
        case (state)
`ifdef ALU_SEQ_OPCHK_EN
          GET_OP: begin
            if (bad_op) begin
              err_opcode <= 1'b1;
              drain_cnt  <= '0;
            end else begin
              opc_q <= in_data[OPC_W-1:0];
            end
          end
          DRAIN: drain_cnt <= drain_cnt + 2'd1;
`else
          GET_OP: opc_q <= in_data[OPC_W-1:0];
`endif
          GET_A: alu_a <= in_data;
          GET_B: begin
            alu_b    <= in_data;
            exec_cnt <= EW'(EXEC_CYCLES - 1);
          end
          default: ;
        endcase
      end
    end
  end

  alu_seq_result_reg u_res (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .y          (alu_y),
    .op         (opc_q),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_opcode (res_opcode),
    .done       (done)
  );
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench: DUT0 (EXEC_CYCLES=1, CNT_W=2) and DUT1 (EXEC_CYCLES=3, CNT_W=8), each with an a+b ALU stub.
module tb_alu_cmd_sequencer;
  logic       clk, rst;
  logic       iv [2];
  logic [7:0] id [2];
  logic       rr [2];
  logic       ir [2];
  logic       rv [2];
  logic       bz [2];
  logic [2:0] aop [2];
  logic [2:0] rop [2];
  logic [7:0] aa [2];
  logic [7:0] ab [2];
  logic [7:0] ay [2];
  logic [7:0] rd [2];
  logic [1:0] cnt0;
  logic [7:0] cnt1;
`ifdef ALU_SEQ_OPCHK_EN
  logic       err [2];
`endif

  int total = 0;
  int bad   = 0;

  assign ay[0] = aa[0] + ab[0];
  assign ay[1] = aa[1] + ab[1];

  alu_cmd_sequencer #(.EXEC_CYCLES(1), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
    .alu_opcode(aop[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_y(ay[0]),
    .res_valid(rv[0]), .res_ready(rr[0]), .res_data(rd[0]), .res_opcode(rop[0]),
    .cmd_count(cnt0), .busy(bz[0])
`ifdef ALU_SEQ_OPCHK_EN
    , .err_opcode(err[0])
`endif
  );

  alu_cmd_sequencer #(.EXEC_CYCLES(3), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
    .alu_opcode(aop[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_y(ay[1]),
    .res_valid(rv[1]), .res_ready(rr[1]), .res_data(rd[1]), .res_opcode(rop[1]),
    .cmd_count(cnt1), .busy(bz[1])
`ifdef ALU_SEQ_OPCHK_EN
    , .err_opcode(err[1])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Holds the byte until accepted; returns 1 time unit after the transfer edge.
  task automatic send_byte(input int d, input logic [7:0] b);
    int g = 0;
    iv[d] = 1'b1; id[d] = b;
    while (!ir[d] && g < 100) begin tick(); g++; end
    if (g >= 100) chk("send_timeout", 32'd0, 32'd1);
    tick();
    iv[d] = 1'b0;
  endtask

  // lat = edges from the B transfer until res_valid is seen.
  task automatic do_cmd(input int d, input logic [7:0] op, input logic [7:0] a,
                        input logic [7:0] b, output int lat);
    send_byte(d, op); send_byte(d, a); send_byte(d, b);
    lat = 0;
    while (!rv[d] && lat < 50) begin tick(); lat++; end
  endtask

  typedef struct {
    logic [7:0] op, a, b;
    logic [7:0] y;
    logic [2:0] rop;
    logic [1:0] cnt;
  } vec_t;

  vec_t vt [4];

  initial begin
    int lat;
    logic a_ok;
    vt[0] = '{op:8'h00, a:8'h0C, b:8'h22, y:8'h2E, rop:3'd0, cnt:2'd2};
    vt[1] = '{op:8'h03, a:8'hF0, b:8'h20, y:8'h10, rop:3'd3, cnt:2'd3};
    vt[2] = '{op:8'h07, a:8'hFF, b:8'hFF, y:8'hFE, rop:3'd7, cnt:2'd0};
    vt[3] = '{op:8'h02, a:8'h01, b:8'h02, y:8'h03, rop:3'd2, cnt:2'd1};

    for (int d = 0; d < 2; d++) begin iv[d] = 0; id[d] = 0; rr[d] = 0; end
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    chk("rst_valid", 32'(rv[0]), 0);
    chk("rst_busy", 32'(bz[0]), 0);
    chk("rst_in_ready", 32'(ir[0]), 1);
    chk("rst_opcode", 32'(aop[0]), 0);
    chk("rst_a", 32'(aa[0]), 0);
    chk("rst_b", 32'(ab[0]), 0);
    chk("rst_res_data", 32'(rd[0]), 0);
    chk("rst_res_op", 32'(rop[0]), 0);
    chk("rst_count", 32'(cnt0), 0);

    // Reset mid-command discards the partial command.
    send_byte(0, 8'h03); send_byte(0, 8'h10);
    chk("mid_busy", 32'(bz[0]), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mid_rst_busy", 32'(bz[0]), 0);
    chk("mid_rst_op", 32'(aop[0]), 0);
    chk("mid_rst_a", 32'(aa[0]), 0);
    rr[0] = 1'b1;
    do_cmd(0, 8'h00, 8'h05, 8'h07, lat);
    chk("mid_res_data", 32'(rd[0]), 32'h0C);
    tick();
    chk("mid_count", 32'(cnt0), 1);

    // Table: latency, result and wrapping 2-bit count.
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, vt[i].op, vt[i].a, vt[i].b, lat);
      chk("tbl_latency", 32'(lat), 2);
      chk("tbl_res_data", 32'(rd[0]), 32'(vt[i].y));
      chk("tbl_res_op", 32'(rop[0]), 32'(vt[i].rop));
      tick();
      chk("tbl_count", 32'(cnt0), 32'(vt[i].cnt));
      chk("tbl_valid_drop", 32'(rv[0]), 0);
    end

    // Backpressure: result held stable for 5 cycles.
    rr[0] = 1'b0;
    do_cmd(0, 8'h01, 8'h40, 8'h02, lat);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(rv[0]), 1);
      chk("bp_data", 32'(rd[0]), 32'h42);
      chk("bp_in_ready", 32'(ir[0]), 0);
    end
    chk("bp_count_hold", 32'(cnt0), 1);
    rr[0] = 1'b1;
    tick();
    chk("bp_valid_drop", 32'(rv[0]), 0);
    chk("bp_count", 32'(cnt0), 2);
    chk("bp_in_ready_back", 32'(ir[0]), 1);

    // DUT1: gapped bytes with EXEC_CYCLES=3.
    rr[1] = 1'b1;
    send_byte(1, 8'h05); tick(); tick();
    send_byte(1, 8'hFF); tick(); tick(); tick();
    send_byte(1, 8'h01);
    lat = 0; a_ok = 1'b1;
    while (!rv[1] && lat < 50) begin
      if (aa[1] !== 8'hFF) a_ok = 1'b0;
      tick(); lat++;
    end
    chk("gap_latency", 32'(lat), 4);
    chk("gap_a_held", 32'(a_ok), 1);
    chk("gap_res_op", 32'(rop[1]), 5);
    chk("gap_res_data", 32'(rd[1]), 0);
    tick();
    chk("gap_count", 32'(cnt1), 1);

    // in_valid during HOLD is not consumed until back in GET_OP.
    rr[1] = 1'b0;
    do_cmd(1, 8'h00, 8'h01, 8'h01, lat);
    iv[1] = 1'b1; id[1] = 8'h04;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_in_ready", 32'(ir[1]), 0);
      chk("hold_op", 32'(aop[1]), 0);
    end
    rr[1] = 1'b1;
    tick();
    chk("hold_done_ready", 32'(ir[1]), 1);
    chk("hold_done_op", 32'(aop[1]), 0);
    chk("hold_count", 32'(cnt1), 2);
    tick();
    iv[1] = 1'b0;
    chk("hold_byte_taken", 32'(aop[1]), 4);

`ifdef ALU_SEQ_OPCHK_EN
    // Bad opcode drains two bytes, then a good command runs.
    chk("opchk_err_clear", 32'(err[0]), 0);
    a_ok = 1'b1;
    send_byte(0, 8'h83); if (aa[0] === 8'h01) a_ok = 1'b0;
    send_byte(0, 8'h01); if (aa[0] === 8'h01) a_ok = 1'b0;
    send_byte(0, 8'h02); if (aa[0] === 8'h01) a_ok = 1'b0;
    chk("opchk_err", 32'(err[0]), 1);
    chk("opchk_idle", 32'(bz[0]), 0);
    chk("opchk_no_result", 32'(rv[0]), 0);
    chk("opchk_count_same", 32'(cnt0), 2);
    do_cmd(0, 8'h01, 8'h04, 8'h04, lat);
    chk("opchk_a_untouched", 32'(a_ok), 1);
    chk("opchk_res_op", 32'(rop[0]), 1);
    chk("opchk_res_data", 32'(rd[0]), 8);
    tick();
    chk("opchk_count", 32'(cnt0), 3);
    chk("opchk_err_sticky", 32'(err[0]), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
